wash_seq: RTL and testbench

- Phase sequencer for the washer controller. On a start request it latches the programme (mode, water level) and steps through the fill, wash, drain, rinse and spin phases.
- It drives the valve, motor and drain actuators and maintains a remaining-time count for the display path.
- It sits between the debounced key/mode logic upstream and the actuator, LED and buzzer drivers downstream. All of those run on the same clock.

---
 rtl/wash_seq.sv | 195 +++++++++++++++++++
 tb/tb_wash_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_seq.sv
// rtl/wash_seq.sv - washer phase sequencer: fill/wash/drain/rinse/spin with pause and remaining-time count
// Programme steps 0..6 are FILL WASH | DRAIN FILL RINSE | DRAIN SPIN, grouped by mode[2], mode[1], mode[0].
module wash_seq #(
   parameter int TIM_UNIT = 100_000_000,
   parameter int WASH_U   = 9,
   parameter int RINSE_U  = 6,
   parameter int SPIN_U   = 3,
   parameter int DRN_U    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       run,
   input  logic [2:0] mode,
   input  logic [2:0] level,
   output logic       busy,
   output logic       paused,
   output logic [2:0] phase,
   output logic       valve,
   output logic [1:0] motor,
   output logic       drain,
   output logic [7:0] remain,
   output logic       done
);

   localparam int            PW      = (TIM_UNIT > 1) ? $clog2(TIM_UNIT) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TIM_UNIT - 1);
   localparam logic [2:0]    NO_STEP = 3'd7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      DRAIN = 3'd3,
      RINSE = 3'd4,
      SPIN  = 3'd5,
      PAUSE = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t        state, save_state, n_state, n_save;
   logic [2:0]    step, n_step, mode_l, n_mode, lvl_l, n_lvl, lvl_in, first, nxt;
   logic [7:0]    pcnt, n_pcnt, n_remain;
   logic [PW-1:0] presc, n_presc;
   logic          active, tick;

   function automatic logic step_en(input logic [2:0] s, input logic [2:0] m);
      if (s < 3'd2) return m[2];
      if (s < 3'd5) return m[1];
      return m[0];
   endfunction

   // Lowest enabled step index at or after 'from'; NO_STEP when the programme is exhausted.
   function automatic logic [2:0] find_step(input logic [3:0] from, input logic [2:0] m);
      logic [2:0] f = NO_STEP;
      for (int i = 6; i >= 0; i--) begin
         if (4'(i) >= from && step_en(3'(i), m)) f = 3'(i);
      end
      return f;
   endfunction

   function automatic state_t step_state(input logic [2:0] s);
      case (s)
         3'd0, 3'd3: return FILL;
         3'd1:       return WASH;
         3'd2, 3'd5: return DRAIN;
         3'd4:       return RINSE;
         3'd6:       return SPIN;
         default:    return IDLE;
      endcase
   endfunction

   function automatic logic [7:0] step_units(input logic [2:0] s, input logic [2:0] l);
      case (step_state(s))
         FILL:    return {5'd0, l};
         WASH:    return 8'(WASH_U);
         DRAIN:   return 8'(DRN_U);
         RINSE:   return 8'(RINSE_U);
         SPIN:    return 8'(SPIN_U);
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] total_units(input logic [2:0] m, input logic [2:0] l);
      logic [7:0] t = 8'd0;
      if (m[2]) t = t + {5'd0, l} + 8'(WASH_U);
      if (m[1]) t = t + 8'(DRN_U) + {5'd0, l} + 8'(RINSE_U);
      if (m[0]) t = t + 8'(DRN_U) + 8'(SPIN_U);
      return t;
   endfunction

   always_comb begin
      lvl_in   = (level == 3'd0) ? 3'd1 : (level > 3'd5) ? 3'd5 : level;
      active   = state inside {FILL, WASH, DRAIN, RINSE, SPIN};
      tick     = active && (presc == PRE_MAX);
      first    = find_step(4'd0, mode);
      nxt      = find_step({1'b0, step} + 4'd1, mode_l);
      n_state  = state;
      n_save   = save_state;
      n_step   = step;
      n_mode   = mode_l;
      n_lvl    = lvl_l;
      n_pcnt   = pcnt;
      n_remain = remain;
      n_presc  = presc;
      if (!en) begin
         n_state  = IDLE;
         n_remain = 8'd0;
         n_pcnt   = 8'd0;
         n_presc  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (run && mode != 3'd0) begin
                  n_mode   = mode;
                  n_lvl    = lvl_in;
                  n_step   = first;
                  n_state  = step_state(first);
                  n_pcnt   = step_units(first, lvl_in);
                  n_remain = total_units(mode, lvl_in);
                  n_presc  = '0;
               end
            end
            PAUSE: begin
               if (run) n_state = save_state;
            end
            DONE: begin
               n_state  = IDLE;
               n_remain = 8'd0;
               n_presc  = '0;
            end
            default: begin
               n_presc = tick ? '0 : presc + PW'(1);
               if (tick) begin
                  n_remain = remain - 8'd1;
                  if (pcnt == 8'd1) begin
                     if (nxt == NO_STEP) begin
                        n_state = DONE;
                     end else begin
                        n_step  = nxt;
                        n_state = step_state(nxt);
                        n_pcnt  = step_units(nxt, lvl_l);
                     end
                  end else begin
                     n_pcnt = pcnt - 8'd1;
                  end
               end
               // The tick is applied first, so a pause here resumes into the already-advanced phase.
               if (run && n_state != DONE) begin
                  n_save  = n_state;
                  n_state = PAUSE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         save_state <= IDLE;
         step       <= 3'd0;
         mode_l     <= 3'd0;
         lvl_l      <= 3'd0;
         pcnt       <= 8'd0;
         presc      <= '0;
         remain     <= 8'd0;
         busy       <= 1'b0;
         paused     <= 1'b0;
         phase      <= 3'd0;
         valve      <= 1'b0;
         motor      <= 2'b00;
         drain      <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= n_state;
         save_state <= n_save;
         step       <= n_step;
         mode_l     <= n_mode;
         lvl_l      <= n_lvl;
         pcnt       <= n_pcnt;
         presc      <= n_presc;
         remain     <= n_remain;
         busy       <= (n_state != IDLE);
         paused     <= (n_state == PAUSE);
         phase      <= n_state;
         valve      <= (n_state == FILL);
         motor      <= (n_state == WASH || n_state == RINSE) ? 2'b01 :
                       (n_state == SPIN) ? 2'b10 : 2'b00;
         drain      <= (n_state == DRAIN || n_state == SPIN);
         done       <= (n_state == DONE);
      end
   end

endmodule

// File: tb/tb_wash_seq.sv
// tb/tb_wash_seq.sv - scoreboard bench for wash_seq against a remaining-cycles programme model
module tb_wash_seq;

   localparam int TU = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       run = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [2:0] level = 3'd0;
   logic       busy, paused, valve, drain, done;
   logic [2:0] phase;
   logic [1:0] motor;
   logic [7:0] remain;

   wash_seq #(
      .TIM_UNIT(TU),
      .WASH_U  (3),
      .RINSE_U (2),
      .SPIN_U  (2),
      .DRN_U   (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .run   (run),
      .mode  (mode),
      .level (level),
      .busy  (busy),
      .paused(paused),
      .phase (phase),
      .valve (valve),
      .motor (motor),
      .drain (drain),
      .remain(remain),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] phase;
      logic       busy;
      logic       paused;
      logic       valve;
      logic [1:0] motor;
      logic       drain;
      logic [7:0] remain;
      logic       done;
   } obs_t;

   typedef struct {
      logic [2:0] ph;
      int         cyc;
   } seg_t;

   obs_t exp_q[$];
   seg_t segs[$];
   bit   m_active, m_paused, m_done;
   int   checks = 0;
   int   errors = 0;
   obs_t mon_e, mon_a;

   function automatic obs_t dut_obs();
      obs_t o;
      o.phase  = phase;
      o.busy   = busy;
      o.paused = paused;
      o.valve  = valve;
      o.motor  = motor;
      o.drain  = drain;
      o.remain = remain;
      o.done   = done;
      return o;
   endfunction

   // Remaining time is just the cycles still owed to the programme, rounded up to whole units.
   function automatic obs_t model_out();
      obs_t o = '0;
      int   left = 0;
      foreach (segs[i]) left += segs[i].cyc;
      if (m_done) begin
         o.phase = 3'd7;
         o.busy  = 1'b1;
         o.done  = 1'b1;
      end else if (m_active) begin
         o.busy   = 1'b1;
         o.remain = 8'((left + TU - 1) / TU);
         if (m_paused) begin
            o.phase  = 3'd6;
            o.paused = 1'b1;
         end else begin
            o.phase = segs[0].ph;
            o.valve = (segs[0].ph == 3'd1);
            o.motor = (segs[0].ph == 3'd2 || segs[0].ph == 3'd4) ? 2'b01 :
                      (segs[0].ph == 3'd5) ? 2'b10 : 2'b00;
            o.drain = (segs[0].ph == 3'd3 || segs[0].ph == 3'd5);
         end
      end
      return o;
   endfunction

   task automatic add_seg(input logic [2:0] ph, input int units);
      seg_t s;
      s.ph  = ph;
      s.cyc = units * TU;
      segs.push_back(s);
   endtask

   task automatic model_clear();
      segs.delete();
      m_active = 1'b0;
      m_paused = 1'b0;
      m_done   = 1'b0;
   endtask

   task automatic model_edge(input bit r_n, input bit e, input bit r,
                             input logic [2:0] md, input logic [2:0] lv);
      int l;
      if (!r_n || !e) begin
         model_clear();
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active) begin
         if (r && md != 3'd0) begin
            l = (lv == 0) ? 1 : (lv > 5) ? 5 : int'(lv);
            if (md[2]) begin add_seg(3'd1, l); add_seg(3'd2, 3); end
            if (md[1]) begin add_seg(3'd3, 1); add_seg(3'd1, l); add_seg(3'd4, 2); end
            if (md[0]) begin add_seg(3'd3, 1); add_seg(3'd5, 2); end
            m_active = 1'b1;
         end
      end else if (m_paused) begin
         if (r) m_paused = 1'b0;
      end else begin
         segs[0].cyc = segs[0].cyc - 1;
         if (segs[0].cyc == 0) void'(segs.pop_front());
         if (segs.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end else if (r) begin
            m_paused = 1'b1;
         end
      end
   endtask

   task automatic cycle(input bit r);
      run = r;
      model_edge(rst_n, en, r, mode, level);
      exp_q.push_back(model_out());
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0);
   endtask

   task automatic check_direct(input string name, input obs_t e);
      obs_t a;
      a = dut_obs();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, a, e);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         mon_a = dut_obs();
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL cycle t=%0t got ph=%0d busy=%0b pau=%0b v=%0b m=%0d d=%0b rem=%0d done=%0b exp ph=%0d busy=%0b pau=%0b v=%0b m=%0d d=%0b rem=%0d done=%0b",
                     $time, mon_a.phase, mon_a.busy, mon_a.paused, mon_a.valve, mon_a.motor,
                     mon_a.drain, mon_a.remain, mon_a.done, mon_e.phase, mon_e.busy, mon_e.paused,
                     mon_e.valve, mon_e.motor, mon_e.drain, mon_e.remain, mon_e.done);
         end
      end
   end

   initial begin
      model_clear();
      #3;
      check_direct("reset_state", '0);
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      en    = 1'b1;
      idle(2);

      // Full programme
      mode = 3'b111; level = 3'd2;
      cycle(1'b1);
      idle(56);

      // Spin only
      mode = 3'b001; level = 3'd3;
      cycle(1'b1);
      idle(16);

      // Pause mid-WASH for 20 cycles
      mode = 3'b100; level = 3'd1;
      cycle(1'b1);
      idle(8);
      cycle(1'b1);
      idle(20);
      cycle(1'b1);
      idle(16);

      // Run landing on the FILL-ending tick: resume must land in WASH
      cycle(1'b1);
      idle(3);
      cycle(1'b1);
      idle(3);
      cycle(1'b1);
      idle(16);

      // Level clamp and mode=0
      mode = 3'b100; level = 3'd0;
      cycle(1'b1);
      idle(18);
      level = 3'd7;
      cycle(1'b1);
      idle(34);
      mode = 3'b000;
      cycle(1'b1);
      idle(3);

      // Run in DONE is ignored
      mode = 3'b001; level = 3'd1;
      cycle(1'b1);
      idle(12);
      cycle(1'b1);
      idle(3);

      // en drop during RINSE, then restart
      mode = 3'b010; level = 3'd1;
      cycle(1'b1);
      idle(10);
      en = 1'b0;
      cycle(1'b1);
      en = 1'b1;
      idle(2);
      cycle(1'b1);
      idle(18);

      // Asynchronous reset mid-SPIN
      mode = 3'b001; level = 3'd1;
      cycle(1'b1);
      idle(6);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_direct("async_reset", '0);
      @(negedge clk);
      idle(3);
      rst_n = 1'b1;
      idle(5);
      cycle(1'b1);
      idle(14);

      // Randomized programmes with pauses, input churn and occasional en drops
      for (int p = 0; p < 25; p++) begin
         bit prev;
         mode  = 3'($urandom_range(0, 7));
         level = 3'($urandom_range(0, 7));
         en    = 1'b1;
         cycle(1'b1);
         prev = 1'b1;
         for (int c = 0; c < 200 && (m_active || m_done); c++) begin
            bit r;
            r = !prev && ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 9) == 0) begin
               mode  = 3'($urandom_range(0, 7));
               level = 3'($urandom_range(0, 7));
            end
            en = ($urandom_range(0, 249) != 0);
            cycle(r);
            prev = r;
         end
         en = 1'b1;
         idle(2);
      end

      idle(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue got=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
